conv_line_buffer: RTL and testbench

Upstream feeder for the convolution stage. It accepts a raster-order pixel stream, one BIT_LEN-bit pixel per valid cycle, and holds the previous M_LEN-1 image lines in on-chip line memories. For every pixel it emits the M_LEN-tall vertical column ending at that pixel on o_data_img, together with the o_selec_I strobe the convolution stage consumes. Kernel loading (i_selec_K / i_data_kernel) is outside this block.

---
 rtl/conv_line_buffer_pkg.sv | 14 +
 rtl/conv_line_buffer_line_mem.sv | 23 ++
 rtl/conv_line_buffer.sv | 142 ++++++++++++++
 tb/tb_conv_line_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_line_buffer_pkg.sv
// Shared definitions for the convolution line buffer and the convolution stage.
// The convolution stage depends on this column packing: the MSB slice is the oldest row and the LSB slice is the current pixel.
package conv_line_buffer_pkg;

  localparam int DEF_BIT_LEN = 8;
  localparam int DEF_M_LEN   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/conv_line_buffer_line_mem.sv
// One image line of storage with a single clock.
// The read is asynchronous, so a read and a write at the same address in one cycle return the old data.
module conv_line_buffer_line_mem #(
  parameter int IMG_W   = 32,
  parameter int BIT_LEN = 8,
  parameter int AW      = 5
) (
  input  logic               i_clk,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [BIT_LEN-1:0] wdata_i,
  output logic [BIT_LEN-1:0] rdata_o
);

  logic [BIT_LEN-1:0] mem_q [IMG_W];

  always_ff @(posedge i_clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_line_buffer.sv
// Raster-stream line buffer: for each pixel it emits the M_LEN-tall column that ends at that pixel, one cycle after the pixel is accepted.
//   state     | meaning
//   ST_IDLE   | no frame in progress; the block waits for i_sof with i_pix_valid
//   ST_FILL   | rows 0..M_LEN-2 are being stored and no column is emitted
//   ST_STREAM | one column is emitted for each accepted pixel until the frame ends
module conv_line_buffer
  import conv_line_buffer_pkg::*;
#(
  parameter int BIT_LEN = DEF_BIT_LEN,
  parameter int M_LEN   = DEF_M_LEN,
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_sof,
  input  logic                     i_pix_valid,
  input  logic [BIT_LEN-1:0]       i_pixel,
  output logic                     o_selec_I,
  output logic [BIT_LEN*M_LEN-1:0] o_data_img,
  output logic                     o_row_start,
  output logic                     o_frame_done,
  output logic                     o_busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(M_LEN - 2);
  localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(M_LEN - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d, pix_col;
  logic [RW-1:0]            row_q, row_d, pix_row;
  logic                     accept, last_pix, fill_done, emit;
  logic                     sel_q, row_start_q, frame_done_q;
  logic [BIT_LEN*M_LEN-1:0] data_q, column;
  logic [BIT_LEN-1:0]       rd [M_LEN-1];
  logic [BIT_LEN-1:0]       wr [M_LEN-1];

  // i_sof overrides the running counters, so the pixel that arrives with it is always (0,0)
  assign accept    = i_pix_valid & (i_sof | (state_q != ST_IDLE));
  assign pix_col   = i_sof ? '0 : col_q;
  assign pix_row   = i_sof ? '0 : row_q;
  assign last_pix  = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
  assign fill_done = (pix_row == ROW_FILL_LAST) && (pix_col == COL_LAST);
  assign emit      = accept && (pix_row >= ROW_FIRST_OUT);

  for (genvar k = 0; k < M_LEN - 1; k++) begin : g_line
    if (k == 0) begin : g_head
      assign wr[k] = i_pixel;
    end else begin : g_shift
      assign wr[k] = rd[k-1];
    end
    conv_line_buffer_line_mem #(
      .IMG_W  (IMG_W),
      .BIT_LEN(BIT_LEN),
      .AW     (CW)
    ) u_line_mem (
      .i_clk  (i_clk),
      .we_i   (accept),
      .addr_i (pix_col),
      .wdata_i(wr[k]),
      .rdata_o(rd[k])
    );
  end

  always_comb begin
    column = '0;
    column[BIT_LEN-1:0] = i_pixel;
    for (int k = 0; k < M_LEN - 1; k++) begin
      column[(k+1)*BIT_LEN +: BIT_LEN] = rd[k];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_sof && (i_pix_valid || (state_q != ST_IDLE))) begin
      col_d = '0;
      row_d = '0;
    end
    if (accept) begin
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = last_pix ? '0 : pix_row + 1'b1;
      end else begin
        col_d = pix_col + 1'b1;
        row_d = pix_row;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_sof && i_pix_valid) state_d = ST_FILL;
      ST_FILL:   if (i_sof) state_d = ST_FILL;
                 else if (accept && fill_done) state_d = ST_STREAM;
      ST_STREAM: if (i_sof) state_d = ST_FILL;
                 else if (accept && last_pix) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // o_data_img is not updated when no column is emitted
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sel_q        <= 1'b0;
      row_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_q       <= '0;
    end else begin
      sel_q        <= emit;
      row_start_q  <= emit && (pix_col == '0);
      frame_done_q <= emit && last_pix;
      if (emit) data_q <= column;
    end
  end

  always_comb begin
    o_selec_I    = sel_q;
    o_data_img   = data_q;
    o_row_start  = row_start_q;
    o_frame_done = frame_done_q;
    o_busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Testbench for conv_line_buffer with a 4x4 image and a kernel height of 3.
// Expected columns are computed from the pixels driven into the current frame and then compared in order against the DUT output.
module tb_conv_line_buffer;

  localparam int BL = 8;
  localparam int ML = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = BL * ML;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_sof = 1'b0;
  logic          i_pix_valid = 1'b0;
  logic [BL-1:0] i_pixel = '0;
  logic          o_selec_I, o_row_start, o_frame_done, o_busy;
  logic [DW-1:0] o_data_img;

  conv_line_buffer #(.BIT_LEN(BL), .M_LEN(ML), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_sof       (i_sof),
    .i_pix_valid (i_pix_valid),
    .i_pixel     (i_pixel),
    .o_selec_I   (o_selec_I),
    .o_data_img  (o_data_img),
    .o_row_start (o_row_start),
    .o_frame_done(o_frame_done),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          rs;
    logic          fd;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            fd_cnt = 0;
  int            sel_cnt = 0;
  logic          mon_en = 1'b0;
  logic          exp_sel = 1'b0;
  logic          m_active = 1'b0;
  int            m_r = 0;
  int            m_c = 0;
  logic [BL-1:0] img [H][W];

  function automatic logic [BL-1:0] pv(input int r, input int c);
    return BL'(16 * r + c + 1);
  endfunction

  // Frame-level model: every accepted pixel at row >= 2 yields {row r-2, row r-1, row r} at column c.
  task automatic cycle(input logic sof, input logic valid, input logic [BL-1:0] pix);
    logic acc, nxt_sel;
    exp_t e;
    nxt_sel = 1'b0;
    acc = valid && (sof || m_active);
    if (sof && (valid || m_active)) begin
      m_r = 0; m_c = 0; m_active = 1'b1;
    end
    if (acc) begin
      img[m_r][m_c] = pix;
      if (m_r >= ML - 1) begin
        e.data = {img[m_r-2][m_c], img[m_r-1][m_c], pix};
        e.rs   = (m_c == 0);
        e.fd   = (m_r == H - 1) && (m_c == W - 1);
        sb.push_back(e);
        nxt_sel = 1'b1;
      end
      if (m_c == W - 1) begin
        m_c = 0;
        if (m_r == H - 1) begin
          m_r = 0; m_active = 1'b0;
        end else m_r++;
      end else m_c++;
    end
    i_sof = sof; i_pix_valid = valid; i_pixel = pix;
    @(posedge i_clk); #1;
    exp_sel = nxt_sel;
    i_sof = 1'b0; i_pix_valid = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      exp_t e;
      n_tests++;
      if (o_selec_I !== exp_sel) begin
        n_fail++;
        $display("FAIL selec_I t=%0t got=%b exp=%b", $time, o_selec_I, exp_sel);
      end
      if (o_selec_I === 1'b1) begin
        sel_cnt++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow t=%0t got column %h, exp none", $time, o_data_img);
        end else begin
          e = sb.pop_front();
          if (o_data_img !== e.data || o_row_start !== e.rs || o_frame_done !== e.fd) begin
            n_fail++;
            $display("FAIL column t=%0t got=%h rs=%b fd=%b exp=%h rs=%b fd=%b", $time,
                     o_data_img, o_row_start, o_frame_done, e.data, e.rs, e.fd);
          end
        end
      end else begin
        n_tests++;
        if (o_row_start !== 1'b0 || o_frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL strobes_idle t=%0t got rs=%b fd=%b exp 0 0", $time, o_row_start, o_frame_done);
        end
      end
      if (o_frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    n_tests++;
    if ({o_selec_I, o_data_img, o_row_start, o_frame_done, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got sel=%b data=%h rs=%b fd=%b busy=%b exp all 0",
               o_selec_I, o_data_img, o_row_start, o_frame_done, o_busy);
    end
    i_reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_fill();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) begin
        cycle((r == 0 && c == 0), 1'b1, pv(r, c));
        n_tests++;
        if (o_selec_I !== 1'b0 || o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL fill (%0d,%0d) got sel=%b busy=%b exp sel=0 busy=1", r, c, o_selec_I, o_busy);
        end
      end
    end
  endtask

  task automatic test_stream();
    cycle(1'b0, 1'b1, pv(2, 0));
    n_tests++;
    if (o_selec_I !== 1'b1 || o_data_img !== 24'h011121 || o_row_start !== 1'b1) begin
      n_fail++;
      $display("FAIL first_col got sel=%b data=%h rs=%b exp 1 011121 1", o_selec_I, o_data_img, o_row_start);
    end
    cycle(1'b0, 1'b1, pv(2, 1));
    n_tests++;
    if (o_data_img !== 24'h021222 || o_row_start !== 1'b0) begin
      n_fail++;
      $display("FAIL second_col got data=%h rs=%b exp 021222 0", o_data_img, o_row_start);
    end
    for (int c = 2; c < W; c++) cycle(1'b0, 1'b1, pv(2, c));
    for (int c = 0; c < W; c++) cycle(1'b0, 1'b1, pv(3, c));
    n_tests++;
    if (o_data_img !== 24'h142434 || o_frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL last_col got data=%h fd=%b exp 142434 1", o_data_img, o_frame_done);
    end
    cycle(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (o_frame_done !== 1'b0 || o_busy !== 1'b0 || o_data_img !== 24'h142434) begin
      n_fail++;
      $display("FAIL after_frame got fd=%b busy=%b data=%h exp 0 0 142434", o_frame_done, o_busy, o_data_img);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h55);
      n_tests++;
      if (o_selec_I !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_sof got sel=%b busy=%b exp 0 0", o_selec_I, o_busy);
      end
    end
  endtask

  task automatic test_gaps();
    int sel0;
    sel0 = sel_cnt;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) cycle((r == 0 && c == 0), 1'b1, pv(r, c));
    cycle(1'b0, 1'b1, pv(2, 0));
    cycle(1'b0, 1'b1, pv(2, 1));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      n_tests++;
      if (o_selec_I !== 1'b0 || o_data_img !== 24'h021222) begin
        n_fail++;
        $display("FAIL gap_%0d got sel=%b data=%h exp 0 021222", i, o_selec_I, o_data_img);
      end
    end
    cycle(1'b0, 1'b1, pv(2, 2));
    n_tests++;
    if (o_data_img !== 24'h031323) begin
      n_fail++;
      $display("FAIL after_gap got data=%h exp 031323", o_data_img);
    end
    cycle(1'b0, 1'b1, pv(2, 3));
    for (int c = 0; c < W; c++) cycle(1'b0, 1'b1, pv(3, c));
    cycle(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (sel_cnt - sel0 != 8 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL gap_count got cols=%0d pending=%0d exp 8 0", sel_cnt - sel0, sb.size());
    end
  endtask

  task automatic test_async_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) cycle((r == 0 && c == 0), 1'b1, pv(r, c));
    cycle(1'b0, 1'b1, pv(2, 0));
    cycle(1'b0, 1'b1, pv(2, 1));
    #2 i_reset = 1'b0;
    exp_sel = 1'b0;
    sb.delete();
    m_active = 1'b0;
    #1;
    n_tests++;
    if ({o_selec_I, o_data_img, o_row_start, o_frame_done, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got sel=%b data=%h rs=%b fd=%b busy=%b exp all 0",
               o_selec_I, o_data_img, o_row_start, o_frame_done, o_busy);
    end
    @(negedge i_clk); #1;
    i_reset = 1'b1;
    cycle(1'b0, 1'b1, pv(2, 2));
    n_tests++;
    if (o_selec_I !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_no_sof got sel=%b busy=%b exp 0 0", o_selec_I, o_busy);
    end
    test_fill();
  endtask

  task automatic test_abort();
    int fd0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) cycle((r == 0 && c == 0), 1'b1, pv(r, c));
    cycle(1'b0, 1'b1, pv(2, 0));
    fd0 = fd_cnt;
    cycle(1'b1, 1'b1, 8'hAA);
    n_tests++;
    if (o_selec_I !== 1'b0 || o_frame_done !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort got sel=%b fd=%b busy=%b exp 0 0 1", o_selec_I, o_frame_done, o_busy);
    end
    for (int c = 1; c < W; c++) cycle(1'b0, 1'b1, pv(0, c));
    for (int c = 0; c < W; c++) begin
      cycle(1'b0, 1'b1, pv(1, c));
      n_tests++;
      if (o_selec_I !== 1'b0) begin
        n_fail++;
        $display("FAIL refill (1,%0d) got sel=%b exp 0", c, o_selec_I);
      end
    end
    cycle(1'b0, 1'b1, pv(2, 0));
    n_tests++;
    if (o_data_img !== 24'hAA1121 || o_row_start !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_first_col got data=%h rs=%b exp AA1121 1", o_data_img, o_row_start);
    end
    for (int c = 1; c < W; c++) cycle(1'b0, 1'b1, pv(2, c));
    for (int c = 0; c < W; c++) cycle(1'b0, 1'b1, pv(3, c));
    cycle(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (fd_cnt != fd0 + 1) begin
      n_fail++;
      $display("FAIL abort_frame_done got=%0d exp=%0d", fd_cnt - fd0, 1);
    end
  endtask

  task automatic test_sof_on_last();
    int fd0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (!(r == H - 1 && c == W - 1)) cycle((r == 0 && c == 0), 1'b1, pv(r, c));
    fd0 = fd_cnt;
    cycle(1'b1, 1'b1, 8'hC3);
    n_tests++;
    if (o_selec_I !== 1'b0 || o_frame_done !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sof_on_last got sel=%b fd=%b busy=%b exp 0 0 1", o_selec_I, o_frame_done, o_busy);
    end
    for (int c = 1; c < W; c++) cycle(1'b0, 1'b1, pv(0, c));
    for (int r = 1; r < H; r++)
      for (int c = 0; c < W; c++) cycle(1'b0, 1'b1, pv(r, c));
    cycle(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (fd_cnt != fd0 + 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sof_on_last_end got fd=%0d busy=%b exp 1 0", fd_cnt - fd0, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_gaps();
    test_async_reset();
    test_abort();
    test_sof_on_last();
    repeat (2) cycle(1'b0, 1'b0, 8'h00);
    mon_en = 1'b0;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got pending=%0d exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
